// File: rtl/adc_emu_pkg.sv
// Shared types, defaults and sample-tag helper for the ADC emulator.
// Imported by the emulator top and its synchronizer.
package adc_emu_pkg;

    localparam int NUM_CH_D      = 8;
    localparam int DATA_W_D      = 16;
    localparam int BUSY_CYCLES_D = 108;
    localparam int SYNC_STAGES_D = 2;
    localparam int CONV_CNT_W    = 13;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READOUT
    } state_t;

    // Channel in the top bits so every captured word identifies its source.
    function automatic logic [15:0] sample_tag(
        input logic [2:0]            ch,
        input logic [CONV_CNT_W-1:0] n
    );
        return {ch, n};
    endfunction

endpackage

// File: rtl/adc_emulator_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the AND of its bits.
// A single-bit instance is a plain synchronizer plus edge detector.
module sync_edge #(
    parameter int             W       = 1,
    parameter int             STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic         o_level,
    output logic         o_rise,
    output logic         o_fall
);

    logic [W-1:0] r_sync [STAGES];
    logic         r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) r_sync[i] <= RST_VAL;
            r_prev <= &RST_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= o_level;
        end
    end

    assign o_level = &r_sync[STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/adc_emulator.sv
// Board stand-in for the 8-channel parallel ADC: answers the driver's
// convst / RD_N handshake with deterministic channel-tagged samples.
module adc_emulator
    import adc_emu_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_D,
    parameter int DATA_W      = DATA_W_D,
    parameter int BUSY_CYCLES = BUSY_CYCLES_D,
    parameter int SYNC_STAGES = SYNC_STAGES_D
) (
    input  logic                  CLOCK_27M,
    input  logic                  rst,
    input  logic                  convst_A,
    input  logic                  convst_B,
    input  logic                  convst_C,
    input  logic                  convst_D,
    input  logic                  RD_N,
    input  logic                  ADC_CS_N,
    input  logic                  ADCrst,
    input  logic                  pattern_sel,
    output logic [DATA_W-1:0]     DB,
    output logic                  Busy,
    output logic                  convst_err,
    output logic [CONV_CNT_W-1:0] conv_cnt
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(BUSY_CYCLES - 1);

    logic w_cv_rise, w_cv_fall, w_cv_lvl;
    logic w_rd_rise, w_rd_fall, w_rd_lvl;
    logic w_cs_rise, w_cs_fall, w_cs_lvl;
    logic w_ar_rise, w_ar_fall, w_ar_lvl;
    logic w_unused;

    sync_edge #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'b0000)) u_sync_cv (
        .i_clk(CLOCK_27M), .i_rst(rst),
        .i_d({convst_A, convst_B, convst_C, convst_D}),
        .o_level(w_cv_lvl), .o_rise(w_cv_rise), .o_fall(w_cv_fall)
    );

    sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
        .i_clk(CLOCK_27M), .i_rst(rst), .i_d(RD_N),
        .o_level(w_rd_lvl), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
    );

    sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(CLOCK_27M), .i_rst(rst), .i_d(ADC_CS_N),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ar (
        .i_clk(CLOCK_27M), .i_rst(rst), .i_d(ADCrst),
        .o_level(w_ar_lvl), .o_rise(w_ar_rise), .o_fall(w_ar_fall)
    );

    assign w_unused = ^{w_cv_lvl, w_cv_fall, w_rd_lvl, w_rd_rise,
                        w_cs_rise, w_cs_fall, w_ar_rise, w_ar_fall};

    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_busy_cnt;
    logic                  r_busy;
    logic                  r_err;
    logic [CONV_CNT_W-1:0] r_conv_cnt;
    logic [CONV_CNT_W-1:0] w_cnt_nx;
    logic [CH_W-1:0]       r_ch_idx;
    logic [DATA_W-1:0]     r_db;
    logic [DATA_W-1:0]     r_shadow [NUM_CH];
    logic [DATA_W-1:0]     r_acc    [NUM_CH];
    logic                  w_read, w_conv, w_last, w_serve;
    logic                  w_start, w_err;

    assign w_read   = w_rd_fall & ~w_cs_lvl;
    assign w_conv   = w_cv_rise;
    assign w_last   = (r_ch_idx == CH_W'(NUM_CH - 1));
    assign w_serve  = w_read && (r_state != CONVERT);
    assign w_cnt_nx = r_conv_cnt + 1'b1;

    always_ff @(posedge CLOCK_27M or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A convst racing the final read of a frame is a clean back-to-back start.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_err   = 1'b0;
        if (w_ar_lvl) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_conv) begin
                        w_next  = CONVERT;
                        w_start = 1'b1;
                    end
                end
                CONVERT: begin
                    w_err = w_conv;
                    if (r_busy_cnt == '0) w_next = READOUT;
                end
                READOUT: begin
                    if (w_conv) begin
                        w_next  = CONVERT;
                        w_start = 1'b1;
                        w_err   = !(w_read && w_last);
                    end else if (w_read && w_last) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_27M or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
            r_conv_cnt <= '0;
            r_ch_idx   <= '0;
            r_db       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
                r_acc[c]    <= '0;
            end
        end else if (w_ar_lvl) begin
            r_busy     <= 1'b0;
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
            r_conv_cnt <= '0;
            r_ch_idx   <= '0;
            r_db       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
                r_acc[c]    <= '0;
            end
        end else begin
            if (w_start) begin
                r_busy     <= 1'b1;
                r_busy_cnt <= BUSY_LD;
            end else if (r_state == CONVERT) begin
                if (r_busy_cnt != '0) begin
                    r_busy_cnt <= r_busy_cnt - 1'b1;
                end else begin
                    r_busy     <= 1'b0;
                    r_conv_cnt <= w_cnt_nx;
                    r_ch_idx   <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (pattern_sel) begin
                            r_acc[c]    <= r_acc[c] + DATA_W'((c + 1) * 64);
                            r_shadow[c] <= r_acc[c] + DATA_W'((c + 1) * 64);
                        end else begin
                            r_shadow[c] <= DATA_W'(sample_tag(3'(c), w_cnt_nx));
                        end
                    end
                end
            end
            if (w_serve) begin
                r_db     <= r_shadow[r_ch_idx];
                r_ch_idx <= w_last ? '0 : r_ch_idx + 1'b1;
            end
            if (w_err) r_err <= 1'b1;
        end
    end

    assign DB         = r_db;
    assign Busy       = r_busy;
    assign convst_err = r_err;
    assign conv_cnt   = r_conv_cnt;

endmodule

// File: tb/tb_adc_emulator.sv
// Directed bench for adc_emulator: conversion timing, readout order,
// pattern data, error flag, chip-select gating and converter reset.
module tb_adc_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        convst;
    logic        RD_N;
    logic        ADC_CS_N;
    logic        ADCrst;
    logic        pattern_sel;
    logic [15:0] DB;
    logic        Busy;
    logic        convst_err;
    logic [12:0] conv_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adc_emulator dut (
        .CLOCK_27M  (clk),
        .rst        (rst),
        .convst_A   (convst),
        .convst_B   (convst),
        .convst_C   (convst),
        .convst_D   (convst),
        .RD_N       (RD_N),
        .ADC_CS_N   (ADC_CS_N),
        .ADCrst     (ADCrst),
        .pattern_sel(pattern_sel),
        .DB         (DB),
        .Busy       (Busy),
        .convst_err (convst_err),
        .conv_cnt   (conv_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd();
        RD_N = 1'b0;
        tick(3);
        RD_N = 1'b1;
        tick(3);
    endtask

    task automatic pulse_cv();
        convst = 1'b1;
        tick(3);
        convst = 1'b0;
    endtask

    // Busy must be low two edges after the pin rises and high on the third.
    task automatic start_conv(input string tag);
        convst = 1'b1;
        tick(2);
        chk({tag, "_busy_lat0"}, Busy, 1'b0);
        tick(1);
        chk({tag, "_busy_lat1"}, Busy, 1'b1);
        convst = 1'b0;
    endtask

    task automatic wait_low(input string tag, output int n);
        n = 0;
        while (Busy && n < 1000) begin
            tick(1);
            n++;
        end
        chk({tag, "_busy_timeout"}, 32'(n < 1000), 1);
    endtask

    int n;
    int c;
    int k;

    initial begin
        rst         = 1'b1;
        convst      = 1'b0;
        RD_N        = 1'b1;
        ADC_CS_N    = 1'b0;
        ADCrst      = 1'b0;
        pattern_sel = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(4);

        chk("rst_db",   DB,         16'h0);
        chk("rst_busy", Busy,       1'b0);
        chk("rst_err",  convst_err, 1'b0);
        chk("rst_cnt",  conv_cnt,   13'd0);

        start_conv("c1");
        wait_low("c1", n);
        chk("c1_width", n, 108);
        chk("c1_cnt", conv_cnt, 13'd1);
        chk("c1_err", convst_err, 1'b0);
        for (c = 0; c < 8; c++) begin
            rd();
            chk($sformatf("c1_ch%0d", c), DB, 32'((c << 13) | 1));
        end
        rd();
        chk("idle_wrap_ch0", DB, 16'h0001);

        ADC_CS_N = 1'b1;
        tick(3);
        rd();
        chk("cs_high_db", DB, 16'h0001);
        ADC_CS_N = 1'b0;
        tick(3);
        rd();
        chk("cs_low_ch1", DB, 16'h2001);

        start_conv("c2");
        rd();
        chk("busy_read_db", DB, 16'h2001);
        wait_low("c2", n);
        chk("c2_cnt", conv_cnt, 13'd2);
        chk("c2_err", convst_err, 1'b0);
        rd();
        chk("c2_ch0", DB, 16'h0002);
        rd();
        rd();
        chk("c2_ch2", DB, 16'h4002);

        start_conv("c3");
        chk("early_cv_err", convst_err, 1'b1);
        wait_low("c3", n);
        chk("c3_cnt", conv_cnt, 13'd3);
        rd();
        chk("c3_ch0", DB, 16'h0003);
        for (c = 1; c < 8; c++) rd();
        chk("c3_ch7", DB, 16'hE003);
        chk("err_sticky", convst_err, 1'b1);

        start_conv("c4");
        tick(57);
        ADCrst = 1'b1;
        tick(3);
        chk("ar_busy", Busy, 1'b0);
        chk("ar_db", DB, 16'h0);
        chk("ar_cnt", conv_cnt, 13'd0);
        chk("ar_err", convst_err, 1'b0);
        tick(2);
        ADCrst = 1'b0;
        tick(4);

        start_conv("c5");
        wait_low("c5", n);
        chk("c5_width", n, 108);
        chk("c5_cnt", conv_cnt, 13'd1);
        for (c = 0; c < 8; c++) rd();
        chk("c5_ch7", DB, 16'hE001);
        chk("c5_err", convst_err, 1'b0);

        start_conv("c6");
        tick(20);
        pulse_cv();
        wait_low("c6", n);
        chk("cv_in_conv_width", 23 + n, 108);
        chk("cv_in_conv_err", convst_err, 1'b1);
        chk("c6_cnt", conv_cnt, 13'd2);
        rd();
        chk("c6_ch0", DB, 16'h0002);
        for (c = 1; c < 8; c++) rd();

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("rst2_err", convst_err, 1'b0);

        pattern_sel = 1'b1;
        for (k = 1; k <= 3; k++) begin
            start_conv($sformatf("p1_%0d", k));
            wait_low($sformatf("p1_%0d", k), n);
            rd();
            chk($sformatf("p1_%0d_ch0", k), DB, 32'(k * 64));
            rd();
            rd();
            rd();
            chk($sformatf("p1_%0d_ch3", k), DB, 32'(k * 256));
            for (c = 4; c < 8; c++) rd();
            chk($sformatf("p1_%0d_ch7", k), DB, 32'(k * 512));
        end
        chk("p1_err", convst_err, 1'b0);
        chk("p1_cnt", conv_cnt, 13'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_emulator.md
# adc_emulator

Synthesizable stand-in for the 8-channel, 16-bit parallel-interface ADC, responding to the ADC driver's conversion/read handshake so the driver and SPI path can run on the board without the real converter. Sits between the driver's convst_A..D / RD_N / ADC_CS_N / ADCrst outputs and its DB / Busy inputs. Produces deterministic, channel-tagged sample data so downstream capture can be checked bit-exactly.

## Interface
- NUM_CH, 8: channels per conversion; must be a power of two, at most 8.
- DATA_W, 16: DB width.
- BUSY_CYCLES, 108: Busy high time in clocks (4 us at 27 MHz); at least 1.
- SYNC_STAGES, 2: synchronizer depth on every handshake input; at least 2.
- CLOCK_27M  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- convst_A, convst_B, convst_C, convst_D  in  1 each  conversion start; a conversion starts on the rising edge of their AND.
- RD_N  in  1  read strobe, active low.
- ADC_CS_N  in  1  chip select, active low.
- ADCrst  in  1  converter reset from the driver, active high, synchronous after synchronization.
- pattern_sel  in  1  0 = tagged counter, 1 = per-channel sawtooth; sampled at end of conversion.
- DB  out  DATA_W  parallel sample data.
- Busy  out  1  conversion in progress.
- convst_err  out  1  sticky: a convst edge arrived while busy or before readout finished.
- conv_cnt  out  13  completed-conversion counter, wraps 8191 -> 0.

## Operation
- All four convst bits, RD_N, ADC_CS_N and ADCrst pass through SYNC_STAGES flops. Edge detection compares each synchronized signal with its previous registered value. Synchronizer reset values: convst = 0, RD_N = 1, ADC_CS_N = 1, ADCrst = 0.
- States: IDLE, CONVERT, READOUT.
- IDLE:
  - A convst rising edge goes to CONVERT, sets Busy and loads busy_cnt = BUSY_CYCLES-1.
- CONVERT:
  - busy_cnt decrements each cycle.
  - At busy_cnt == 0: clear Busy, latch all NUM_CH samples into shadow registers, increment conv_cnt, set ch_idx = 0, go to READOUT.
  - A convst edge here is ignored and sets convst_err.
  - Reads here are ignored, and DB holds its value.
- READOUT:
  - A read is an RD_N falling edge with synchronized ADC_CS_N low in the same cycle.
  - Each read does DB <= shadow[ch_idx] and ch_idx <= ch_idx+1 mod NUM_CH.
  - After the NUM_CH-th read, go to IDLE.
  - A convst edge before all channels are read sets convst_err and goes to CONVERT; unread data is discarded.
- Reads in IDLE continue from ch_idx, which wraps, re-presenting the same shadow data.
- Sample value for channel c, with N = conv_cnt after the increment:
  - pattern_sel = 0: {c[2:0], N[12:0]}.
  - pattern_sel = 1: acc[c] += (c+1)*64 each conversion, wrapping mod 2^16. acc resets to 0. The shadow register takes the new acc.
- ADCrst (synchronized, level):
  - Same effect as rst on state, Busy, DB, ch_idx, conv_cnt, acc and convst_err.
  - While ADCrst is high, all edges are ignored.
- Simultaneous read edge and convst edge in READOUT: the read is served first (DB updates), then the state goes to CONVERT.

## Timing
- Reset values: DB = 0, Busy = 0, convst_err = 0, conv_cnt = 0; state IDLE, ch_idx = 0.
- Convst to Busy: a pin edge first sampled high at clock edge k gives Busy high after edge k+SYNC_STAGES.
- Busy stays high exactly BUSY_CYCLES clocks.
- Shadow data and conv_cnt are valid in the cycle Busy falls.
- Read latency: an RD_N fall first sampled at edge k updates DB after edge k+SYNC_STAGES.
- The driver must hold RD_N low and high for at least SYNC_STAGES+1 clocks each. Shorter pulses may be missed; that is legal, not an error.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package adc_emu_pkg: state enum (IDLE, CONVERT, READOUT), the sample-tag function, and default constants (NUM_CH, DATA_W, BUSY_CYCLES).
- One sub-module, sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall detection, with a reset-value parameter. It is instantiated per input.

## Test plan
- Reset then one conversion: convst pulse -> Busy high for exactly 108 cycles, starting 2 clocks after the edge. Then 8 reads, pattern 0 -> DB = 0x0001, 0x2001, 0x4001 … 0xE001; conv_cnt = 1; back to IDLE.
- Pattern 1, three conversions, read ch3 each time -> DB = 0x0100, 0x0200, 0x0300.
- convst during CONVERT -> Busy width unchanged; convst_err = 1, and it stays set until rst.
- convst after 3 reads -> convst_err = 1. The new conversion proceeds, and its first read returns ch0 with conv_cnt incremented.
- Reads with ADC_CS_N high, or during Busy -> DB unchanged, ch_idx unchanged. A 9th read in IDLE returns ch0 again.
- ADCrst mid-conversion (busy_cnt = 50) -> Busy = 0 within SYNC_STAGES+1 clocks; DB = 0, conv_cnt = 0. The next convst behaves as after power-on.
